div_sched: RTL and testbench

DIV_SCHED -- requirements
Module: div_sched

---
 rtl/div_sched.sv | 207 ++++++++++++++++++++
 tb/tb_div_sched.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/div_sched.sv
// ---------------------------------------------------------------------------
// div_sched
// Shares one programmable clock divider between two requesters. A
// round-robin arbiter picks a requester and latches its half-period and
// period count. The block then drives a divided clock that is high for
// 'half' cycles and low for 'half' cycles, repeated 'nper' times. At the
// end it pulses done to the granted requester for one cycle.
//
// Ports
//   i_clk            : single clock, all state changes on the rising edge
//   i_rst            : synchronous active-high reset
//   i_req[1:0]       : request per requester (bit i = requester i)
//   i_half0/i_half1  : half-period in clk cycles (0 is treated as 1)
//   i_nper0/i_nper1  : number of full divided periods
//   o_gnt[1:0]       : one-hot grant, held from LOAD through DONE
//   o_done[1:0]      : one-cycle completion pulse to the granted requester
//   o_busy           : high whenever the scheduler is not idle
//   o_div            : registered divided clock
// ---------------------------------------------------------------------------
module div_sched #(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [1:0]       i_req,
    input  logic [CNT_W-1:0] i_half0,
    input  logic [CNT_W-1:0] i_half1,
    input  logic [CNT_W-1:0] i_nper0,
    input  logic [CNT_W-1:0] i_nper1,
    output logic [1:0]       o_gnt,
    output logic [1:0]       o_done,
    output logic             o_busy,
    output logic             o_div
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] C_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] C_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [1:0]       r_gnt;
    logic [1:0]       r_done;
    logic             r_busy;
    logic             r_div;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_per;
    logic [CNT_W-1:0] r_half;
    logic [CNT_W-1:0] r_nper;
    // Last granted requester; starts at 1 so requester 0 wins the first tie.
    logic             r_ptr;

    state_t           w_state_nxt;
    logic [1:0]       w_gnt_nxt;
    logic [1:0]       w_done_nxt;
    logic             w_div_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_per_nxt;
    logic [CNT_W-1:0] w_half_nxt;
    logic [CNT_W-1:0] w_nper_nxt;
    logic             w_ptr_nxt;

    // Index of the granted requester (grant is one-hot, so bit 1 suffices).
    logic             w_g;
    logic             w_req_g;
    logic [CNT_W-1:0] w_half_sel;
    logic [CNT_W-1:0] w_nper_sel;
    logic [CNT_W-1:0] w_per_inc;

    assign w_g        = r_gnt[1];
    assign w_req_g    = w_g ? i_req[1] : i_req[0];
    assign w_half_sel = w_g ? i_half1 : i_half0;
    assign w_nper_sel = w_g ? i_nper1 : i_nper0;
    assign w_per_inc  = r_per + C_ONE;

    // Next-state, datapath and output decode for the scheduler FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_done_nxt  = 2'b00;
        w_div_nxt   = r_div;
        w_cnt_nxt   = r_cnt;
        w_per_nxt   = r_per;
        w_half_nxt  = r_half;
        w_nper_nxt  = r_nper;
        w_ptr_nxt   = r_ptr;

        case (r_state)
            ST_IDLE: begin
                w_div_nxt = 1'b0;
                w_gnt_nxt = 2'b00;
                if (i_req != 2'b00) begin
                    w_state_nxt = ST_LOAD;
                    if (i_req == 2'b01) begin
                        w_gnt_nxt = 2'b01;
                    end else if (i_req == 2'b10) begin
                        w_gnt_nxt = 2'b10;
                    end else begin
                        // Tie: the requester that was not granted last wins.
                        w_gnt_nxt = r_ptr ? 2'b01 : 2'b10;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_LOAD: begin
                w_half_nxt = (w_half_sel == C_ZERO) ? C_ONE : w_half_sel;
                w_nper_nxt = w_nper_sel;
                w_cnt_nxt  = C_ZERO;
                w_per_nxt  = C_ZERO;
                if (!w_req_g) begin
                    w_state_nxt = ST_DONE;
                    w_div_nxt   = 1'b0;
                end else if (w_nper_sel == C_ZERO) begin
                    w_state_nxt = ST_DONE;
                    w_div_nxt   = 1'b0;
                end else begin
                    w_state_nxt = ST_RUN;
                    w_div_nxt   = 1'b1;
                end
            end

            ST_RUN: begin
                if (!w_req_g) begin
                    w_state_nxt = ST_DONE;
                    w_div_nxt   = 1'b0;
                end else if (r_cnt == (r_half - C_ONE)) begin
                    w_cnt_nxt = C_ZERO;
                    if (r_div) begin
                        w_div_nxt = 1'b0;
                    end else begin
                        // A low-to-high toggle closes one full period; the
                        // last one is suppressed so div finishes low.
                        w_per_nxt = w_per_inc;
                        if (w_per_inc == r_nper) begin
                            w_state_nxt = ST_DONE;
                            w_div_nxt   = 1'b0;
                        end else begin
                            w_div_nxt = 1'b1;
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt + C_ONE;
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = 2'b00;
                w_div_nxt   = 1'b0;
                w_ptr_nxt   = w_g;
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = 2'b00;
                w_div_nxt   = 1'b0;
            end
        endcase

        // done is registered so it is high exactly during the DONE cycle.
        if (w_state_nxt == ST_DONE) begin
            w_done_nxt = w_gnt_nxt;
        end else begin
            w_done_nxt = 2'b00;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_gnt   <= 2'b00;
            r_done  <= 2'b00;
            r_busy  <= 1'b0;
            r_div   <= 1'b0;
            r_cnt   <= C_ZERO;
            r_per   <= C_ZERO;
            r_half  <= C_ONE;
            r_nper  <= C_ZERO;
            r_ptr   <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_div   <= w_div_nxt;
            r_cnt   <= w_cnt_nxt;
            r_per   <= w_per_nxt;
            r_half  <= w_half_nxt;
            r_nper  <= w_nper_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    assign o_gnt  = r_gnt;
    assign o_done = r_done;
    assign o_busy = r_busy;
    assign o_div  = r_div;

endmodule

// File: tb/tb_div_sched.sv
// ---------------------------------------------------------------------------
// tb_div_sched
// Self-checking bench for div_sched. Expected per-cycle outputs are pushed
// to a queue when stimulus is applied and popped/compared one per clock,
// sampled 1 ns after the rising edge. Single-requester transfers come from
// a vector table; reset, tie/round-robin, abort and mid-run reset are
// hand-written sequences.
// ---------------------------------------------------------------------------
module tb_div_sched;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic [1:0]       req;
    logic [CNT_W-1:0] half0, half1, nper0, nper1;
    logic [1:0]       gnt, done;
    logic             busy, dv;

    div_sched #(.CNT_W(CNT_W)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_req  (req),
        .i_half0(half0),
        .i_half1(half1),
        .i_nper0(nper0),
        .i_nper1(nper1),
        .o_gnt  (gnt),
        .o_done (done),
        .o_busy (busy),
        .o_div  (dv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] gnt;
        logic [1:0] done;
        logic       busy;
        logic       div;
        logic       drop;   // after this cycle is checked, release req
    } exp_t;

    typedef struct {
        logic [1:0]       req;
        logic [CNT_W-1:0] half;
        logic [CNT_W-1:0] nper;
        string            pattern; // div value in each RUN cycle
    } vec_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%b want=%b", nm, cyc, act, want);
        end
    endtask

    task automatic push(input logic [1:0] g, input logic [1:0] d,
                        input logic b, input logic v, input logic drop);
        exp_t e;
        e.gnt = g; e.done = d; e.busy = b; e.div = v; e.drop = drop;
        exp_q.push_back(e);
    endtask

    // Whole transfer from IDLE: LOAD, RUN pattern, DONE, back to IDLE.
    task automatic push_txn(input logic [1:0] g, input string pat, input logic drop_done);
        push(g, 2'b00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < pat.len(); i++) begin
            push(g, 2'b00, 1'b1, (pat[i] == 8'h31) ? 1'b1 : 1'b0, 1'b0);
        end
        push(g, g, 1'b1, 1'b0, drop_done);
        push(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    // Step one clock per queued record and compare every output.
    task automatic run_queue(input string nm, input logic scramble);
        int   idx;
        exp_t e;
        idx = 0;
        while (exp_q.size() > 0) begin
            @(posedge clk);
            #1;
            cyc++;
            e = exp_q.pop_front();
            chk({nm, ".gnt"},  gnt,          e.gnt);
            chk({nm, ".done"}, done,         e.done);
            chk({nm, ".busy"}, {1'b0, busy}, {1'b0, e.busy});
            chk({nm, ".div"},  {1'b0, dv},   {1'b0, e.div});
            if (e.drop) req = 2'b00;
            // Fields were latched on the previous edge; changing them must not matter.
            if (scramble && idx == 1) begin
                half0 = CNT_W'($urandom_range(0, 9));
                half1 = CNT_W'($urandom_range(0, 9));
                nper0 = CNT_W'($urandom_range(0, 9));
                nper1 = CNT_W'($urandom_range(0, 9));
            end
            idx++;
        end
    endtask

    initial begin
        vec_t vecs[6];
        vecs[0] = '{req: 2'b01, half: 8'd3, nper: 8'd2, pattern: "111000111000"};
        vecs[1] = '{req: 2'b01, half: 8'd5, nper: 8'd0, pattern: ""};
        vecs[2] = '{req: 2'b01, half: 8'd0, nper: 8'd3, pattern: "101010"};
        vecs[3] = '{req: 2'b10, half: 8'd2, nper: 8'd1, pattern: "1100"};
        vecs[4] = '{req: 2'b10, half: 8'd1, nper: 8'd2, pattern: "1010"};
        vecs[5] = '{req: 2'b01, half: 8'd1, nper: 8'd1, pattern: "10"};

        rst = 1'b1; req = 2'b11;
        half0 = 8'd1; half1 = 8'd1; nper0 = 8'd1; nper1 = 8'd1;

        // Reset held two cycles with both requesting.
        push(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        push(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        run_queue("reset", 1'b0);
        rst = 1'b0; req = 2'b00;
        push(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        run_queue("idle", 1'b0);

        // Tie held continuously: grants alternate 0,1,0,1 with one IDLE between.
        req = 2'b11;
        push_txn(2'b01, "10", 1'b0);
        push_txn(2'b10, "10", 1'b0);
        push_txn(2'b01, "10", 1'b0);
        push_txn(2'b10, "10", 1'b0);
        run_queue("tie", 1'b0);
        req = 2'b00;
        push(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        run_queue("tie_end", 1'b0);

        // Table-driven single-requester transfers; the other requester's
        // fields hold distinct values to catch wrong field selection.
        for (int v = 0; v < 6; v++) begin
            if (vecs[v].req == 2'b01) begin
                half0 = vecs[v].half; nper0 = vecs[v].nper;
                half1 = 8'd7;         nper1 = 8'd9;
            end else begin
                half1 = vecs[v].half; nper1 = vecs[v].nper;
                half0 = 8'd6;         nper0 = 8'd0;
            end
            req = vecs[v].req;
            push_txn(vecs[v].req, vecs[v].pattern, 1'b1);
            run_queue($sformatf("vec%0d", v), 1'b1);
        end

        // Abort: req0 dropped during the 6th RUN cycle.
        half0 = 8'd4; nper0 = 8'd5; req = 2'b01;
        push(2'b01, 2'b00, 1'b1, 1'b0, 1'b0);
        push(2'b01, 2'b00, 1'b1, 1'b1, 1'b0);
        push(2'b01, 2'b00, 1'b1, 1'b1, 1'b0);
        push(2'b01, 2'b00, 1'b1, 1'b1, 1'b0);
        push(2'b01, 2'b00, 1'b1, 1'b1, 1'b0);
        push(2'b01, 2'b00, 1'b1, 1'b0, 1'b0);
        push(2'b01, 2'b00, 1'b1, 1'b0, 1'b1);
        push(2'b01, 2'b01, 1'b1, 1'b0, 1'b0);
        push(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        push(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        run_queue("abort", 1'b0);

        // Mid-run reset: no done pulse, pointer back to 1 so a tie grants 0.
        half0 = 8'd4; nper0 = 8'd5; req = 2'b01;
        push(2'b01, 2'b00, 1'b1, 1'b0, 1'b0);
        push(2'b01, 2'b00, 1'b1, 1'b1, 1'b0);
        push(2'b01, 2'b00, 1'b1, 1'b1, 1'b0);
        push(2'b01, 2'b00, 1'b1, 1'b1, 1'b0);
        run_queue("midrun", 1'b0);
        rst = 1'b1;
        push(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        run_queue("midrst", 1'b0);
        rst = 1'b0; req = 2'b00;
        push(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        push(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        run_queue("nodone", 1'b0);
        half0 = 8'd1; half1 = 8'd1; nper0 = 8'd1; nper1 = 8'd1;
        req = 2'b11;
        push_txn(2'b01, "10", 1'b1);
        run_queue("posttie", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case the run ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
